// File: rtl/fault_rst_seq.sv
// fault_rst_seq: turns an encoder fault or a software reset request into a
// timed SoC reset (drain, hold, release). It also keeps a sticky record of
// the cause and address that survives the system reset it drives.
// Only the power-on rstn clears the record or the sequencer itself.
module fault_rst_seq #(
    parameter int          XLEN      = 32,
    parameter int          DRAIN_CYC = 4,
    parameter int          HOLD_CYC  = 16,
    parameter logic [7:0]  SW_CAUSE  = 8'h01
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            fault,
    input  logic [7:0]      fault_cause,
    input  logic [XLEN-1:0] fault_addr,
    input  logic            sw_rst_req,
    input  logic            cause_clr,
    output logic            sys_rstn,
    output logic            busy,
    output logic            cause_vld,
    output logic [7:0]      cause,
    output logic [XLEN-1:0] cause_addr
);

    // Shared DRAIN/HOLD counter. It is sized to the larger window and counts
    // up from 0 to (window - 1). Exit is an equality test, so it never wraps.
    localparam int CNT_MAX = (DRAIN_CYC > HOLD_CYC) ? DRAIN_CYC : HOLD_CYC;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              sys_rstn_reg;
    logic              busy_reg;
    logic              cause_vld_reg;
    logic [7:0]        cause_reg;
    logic [XLEN-1:0]   cause_addr_reg;

    // Sequencer FSM with registered reset/busy outputs and the sticky cause
    // record. Power-on starts in HOLD so that rstn is stretched for the SoC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_HOLD;
            cnt_reg        <= '0;
            sys_rstn_reg   <= 1'b0;
            busy_reg       <= 1'b1;
            cause_vld_reg  <= 1'b0;
            cause_reg      <= '0;
            cause_addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Capture only here: once sequencing starts, the first
                    // cause wins and later events are ignored.
                    if (fault) begin
                        cause_vld_reg  <= 1'b1;
                        cause_reg      <= fault_cause;
                        cause_addr_reg <= fault_addr;
                        state_reg      <= ST_DRAIN;
                        cnt_reg        <= '0;
                        busy_reg       <= 1'b1;
                    end else if (sw_rst_req) begin
                        cause_vld_reg  <= 1'b1;
                        cause_reg      <= SW_CAUSE;
                        cause_addr_reg <= '0;
                        state_reg      <= ST_DRAIN;
                        cnt_reg        <= '0;
                        busy_reg       <= 1'b1;
                    end else if (cause_clr) begin
                        cause_vld_reg  <= 1'b0;
                        cause_reg      <= '0;
                        cause_addr_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The encoder halt is already stalling the buses. Give
                    // in-flight traffic DRAIN_CYC cycles before the reset.
                    if (cnt_reg == DRAIN_LAST) begin
                        state_reg    <= ST_HOLD;
                        cnt_reg      <= '0;
                        sys_rstn_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_reg    <= ST_WAIT;
                        cnt_reg      <= '0;
                        sys_rstn_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    // The encoder fault is sticky until its reset lands. Do
                    // not re-arm until fault is seen low, or it would re-trigger.
                    if (!fault) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_HOLD;
                    cnt_reg      <= '0;
                    sys_rstn_reg <= 1'b0;
                    busy_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign sys_rstn   = sys_rstn_reg;
    assign busy       = busy_reg;
    assign cause_vld  = cause_vld_reg;
    assign cause      = cause_reg;
    assign cause_addr = cause_addr_reg;

endmodule
